tcm_mem_master: RTL and testbench
=================================

# tcm_mem_master

Request/response initiator that drives one port of the 64 KB dual-port TCM RAM (14-bit word address, 4 byte-write strobes, 1-cycle read-first data). It accepts byte-addressed requests on a valid/ready bus and turns them into RAM port cycles. It absorbs the fixed 1-cycle RAM read latency and returns ordered responses through a credit-protected response buffer. It sits between the bench/DMA/debug loader and the TCM port not used by the core.

## Interface
- ADDR_W, 14: RAM word-address width; the window spans 4<<ADDR_W bytes.
- BASE_ADDR, 32'h0000_0000: byte base of the TCM window; bits [ADDR_W+1:0] must be zero.
- DEPTH, 4: response buffer entries; minimum 2; full throughput requires ≥3.
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted on the edge where valid&ready.
- req_addr_i  in  32  byte address.
- req_data_i  in  32  write data.
- req_wr_i  in  4  byte strobes; 4'b0000 = read.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  response consumed on the edge where valid&ready.
- resp_data_o  out  32  RAM word before any write (read-first); 0 on error.
- resp_wr_o  out  1  response belongs to a write.
- resp_err_o  out  1  request was misaligned or outside the window.
- ram_addr_o  out  ADDR_W  RAM word address.
- ram_data_o  out  32  RAM write data.
- ram_wr_o  out  4  RAM byte-write strobes.
- ram_data_i  in  32  RAM registered read data.

## Operation
- Accept: `acc = req_valid_i & req_ready_o`.
- Ready: `req_ready_o = !rst_i & (occ + infl_v < DEPTH)`. `occ` is the buffer occupancy; `infl_v` is the single in-flight flag.
- Error check:
  - `err = (req_addr_i[1:0] != 0) | (req_addr_i[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2])`.
  - Errored requests never reach the RAM.
- RAM drive (combinational in the accept cycle):
  - `ram_addr_o = req_addr_i[ADDR_W+1:2]`.
  - `ram_data_o = req_data_i`.
  - `ram_wr_o = (acc & !err) ? req_wr_i : 4'b0`.
  - Outside accept cycles, ram_wr_o is 0. ram_addr_o and ram_data_o still follow the request inputs (don't-care to the RAM).
- In-flight register: on accept, `infl_v <= 1` and store err and `|req_wr_i`. Otherwise `infl_v <= 0`.
- Capture: in the cycle `infl_v=1`, push {err ? 0 : ram_data_i, wr, err} into the FIFO.
- Response: resp_* comes from the FIFO head. `resp_valid_o = (occ != 0)`.
- Push and pop in the same cycle leave occ unchanged.
- Every accepted request yields exactly one response, in request order. Writes return the overwritten word.
- Partial-strobe writes (e.g. 4'b0100) are legal and update only the selected bytes.

## Timing
- Accept at cycle T: RAM samples on edge ending T; ram_data_i valid in T+1; resp_valid_o high in T+2 at the earliest. Fixed latency is 2 cycles with no backpressure.
- Throughput: 1 request/cycle sustained when DEPTH≥3 and resp_ready_i=1. With DEPTH=2: 1 request per 2 cycles.
- Full: `occ + infl_v == DEPTH` forces req_ready_o=0. Ready reasserts the cycle after a pop.
- Empty: resp_valid_o=0. resp_data_o, resp_wr_o and resp_err_o hold the last head value; they are 0 after reset.
- Pointer wrap-around: modulo DEPTH, with no bubble.
- Reset (any cycle, including mid-burst):
  - Next cycle: occ=0, infl_v=0, pointers=0, resp_valid_o=0, resp_data_o=0, resp_wr_o=0, resp_err_o=0, ram_wr_o=0.
  - req_ready_o=0 while rst_i=1.
  - In-flight and buffered responses are discarded.
  - A RAM write sampled on an edge before reset is not undone.

## Structure
- Shared defines file tcm_defs: TCM_ADDR_W=14, TCM_STRB_W=4, TCM_DATA_W=32, response-entry field widths and bit positions {data, wr, err}.
- Sub-module tcm_resp_fifo: synchronous FIFO with DEPTH and WIDTH parameters, registered head, count output.
- Top level holds the accept/error logic, the in-flight register and the credit compare.

## Test plan
- Read after write: write 0xDEADBEEF, strobe 4'hF, addr 0x100; then read 0x100. Both responses appear 2 cycles after accept. Write response = prior content (0 after RAM init); read response = 0xDEADBEEF, resp_wr_o=0.
- Byte strobe: word 0x11223344, then write 0xAABBCCDD with strobe 4'b0010, then read. Write response = 0x11223344; read response = 0x1122CC44.
- Errors: addr 0x102, and addr 0x10000 with BASE=0. Each gives resp_err_o=1, data 0, ram_wr_o stays 0, and ordering is kept against surrounding good requests.
- Backpressure: 8 back-to-back reads with resp_ready_i=0 and DEPTH=4. Exactly 4 are accepted, then req_ready_o=0. Releasing resp_ready_i drains responses in order and accepts the rest with no loss or duplication.
- Throughput: 64 reads with resp_ready_i=1 and DEPTH=4 complete in 66 cycles. Pointers wrap more than 10 times.
- Reset mid-burst: assert rst_i with 3 responses buffered and 1 in flight. Next cycle all outputs are at reset values; the following requests are served normally.

Source files
------------

// File: rtl/tcm_mem_master_pkg.sv
// Shared TCM widths, response-entry layout and the request address check.
package tcm_mem_master_pkg;

  localparam int unsigned TCM_ADDR_W = 14;
  localparam int unsigned TCM_STRB_W = 4;
  localparam int unsigned TCM_DATA_W = 32;

  // Response entry, MSB to LSB: {data, wr, err}.
  typedef struct packed {
    logic [TCM_DATA_W-1:0] data;
    logic                  wr;
    logic                  err;
  } resp_entry_t;

  localparam int unsigned RESP_W = $bits(resp_entry_t);

  // Misaligned, or outside the window whose offset bits are set in win_mask.
  function automatic logic req_err(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] win_mask);
    return (addr[1:0] != 2'b00) || ((addr & ~win_mask) != (base & ~win_mask));
  endfunction

endpackage

// File: rtl/tcm_resp_fifo.sv
// Synchronous FIFO with a registered head word and an occupancy count.
module tcm_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_pop;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] head_nxt;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop && (count != '0);

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= din;
  end

  // Next count and next head; head holds its value when the FIFO drains.
  always_comb begin
    count_nxt = count;
    head_nxt  = head;
    if (push && !do_pop)      count_nxt = count + CNT_W'(1);
    else if (!push && do_pop) count_nxt = count - CNT_W'(1);
    if (count == '0) begin
      if (push) head_nxt = din;
    end else if (do_pop) begin
      if (count > CNT_W'(1)) head_nxt = mem[inc(rptr)];
      else if (push)         head_nxt = din;
    end
  end

  // Pointers, count and head register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      if (push)   wptr <= inc(wptr);
      if (do_pop) rptr <= inc(rptr);
      count <= count_nxt;
      head  <= head_nxt;
    end
  end

endmodule

// File: rtl/tcm_mem_master.sv
// Valid/ready request initiator for one TCM RAM port with credit-protected ordered responses.
module tcm_mem_master
  import tcm_mem_master_pkg::*;
#(
  parameter int unsigned ADDR_W    = TCM_ADDR_W,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic [TCM_DATA_W-1:0] req_data_i,
  input  logic [TCM_STRB_W-1:0] req_wr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [TCM_DATA_W-1:0] resp_data_o,
  output logic                  resp_wr_o,
  output logic                  resp_err_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [TCM_DATA_W-1:0] ram_data_o,
  output logic [TCM_STRB_W-1:0] ram_wr_o,
  input  logic [TCM_DATA_W-1:0] ram_data_i
);

  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam logic [31:0] WIN_MASK = 32'((64'(1) << (ADDR_W + 2)) - 64'(1));

  logic             acc;
  logic             err;
  logic             infl_v;
  logic             infl_wr;
  logic             infl_err;
  logic [CNT_W-1:0] occ;
  resp_entry_t      push_entry;
  resp_entry_t      head_entry;

  assign err = req_err(req_addr_i, BASE_ADDR, WIN_MASK);

  // Credit check: buffered plus in-flight responses must leave a free slot.
  assign req_ready_o = !rst_i && ((32'(occ) + 32'(infl_v)) < DEPTH);
  assign acc         = req_valid_i && req_ready_o;

  // RAM port is driven straight from the request; only strobes are gated.
  assign ram_addr_o = req_addr_i[ADDR_W+1:2];
  assign ram_data_o = req_data_i;
  assign ram_wr_o   = (acc && !err) ? req_wr_i : '0;

  // In-flight flag covers the one-cycle RAM read latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      infl_v   <= 1'b0;
      infl_wr  <= 1'b0;
      infl_err <= 1'b0;
    end else begin
      infl_v <= acc;
      if (acc) begin
        infl_wr  <= |req_wr_i;
        infl_err <= err;
      end
    end
  end

  // Build the response entry from the RAM read-first data.
  always_comb begin
    push_entry.data = infl_err ? '0 : ram_data_i;
    push_entry.wr   = infl_wr;
    push_entry.err  = infl_err;
  end

  tcm_resp_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(RESP_W)
  ) u_resp_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push (infl_v),
    .din  (push_entry),
    .pop  (resp_valid_o && resp_ready_i),
    .head (head_entry),
    .count(occ)
  );

  assign resp_valid_o = (occ != '0);
  assign resp_data_o  = head_entry.data;
  assign resp_wr_o    = head_entry.wr;
  assign resp_err_o   = head_entry.err;

endmodule

// File: tb/tb_tcm_mem_master.sv
// Scoreboard bench for tcm_mem_master with a behavioural RAM and reference memory.
module tb_tcm_mem_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_wr_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic        resp_wr_o;
  logic        resp_err_o;
  logic [13:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_wr_o;
  logic [31:0] ram_data_i;

  tcm_mem_master #(
    .ADDR_W(14),
    .BASE_ADDR(32'h0000_0000),
    .DEPTH(4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .req_wr_i(req_wr_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o),
    .resp_wr_o(resp_wr_o),
    .resp_err_o(resp_err_o),
    .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o),
    .ram_wr_o(ram_wr_o),
    .ram_data_i(ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        wr;
    logic        err;
    int          acc_cyc;
    bit          exact;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          pop_cnt = 0;
  exp_t        exp_q[$];
  logic [33:0] obs_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] ram [16384];

  always @(posedge clk_i) cyc <= cyc + 1;

  // 64 KB read-first RAM with byte strobes.
  always @(posedge clk_i) begin
    ram_data_i <= ram[ram_addr_o];
    for (int b = 0; b < 4; b++)
      if (ram_wr_o[b]) ram[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0001_0000);
  endfunction

  // Reference model: on every accept, predict the response and update memory.
  always @(negedge clk_i) begin : accept_side
    bit          acc;
    bit          e;
    int          idx;
    exp_t        x;
    logic [31:0] old;
    acc = req_valid_i && req_ready_o;
    e   = model_err(req_addr_i);
    chk("ram_wr", 64'(ram_wr_o), (acc && !e) ? 64'(req_wr_i) : 64'h0);
    if (rst_i) begin
      exp_q.delete();
    end else if (acc) begin
      idx = int'(req_addr_i >> 2);
      if (!e) begin
        chk("ram_addr", 64'(ram_addr_o), 64'(idx));
        if (req_wr_i != 4'h0) chk("ram_data", 64'(ram_data_o), 64'(req_data_i));
      end
      old       = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      x.data    = e ? 32'h0 : old;
      x.wr      = (req_wr_i != 4'h0);
      x.err     = e;
      x.acc_cyc = cyc;
      x.exact   = (exp_q.size() == 0) || exp_q[$].exact;
      if (!e) begin
        for (int b = 0; b < 4; b++)
          if (req_wr_i[b]) old[8*b +: 8] = req_data_i[8*b +: 8];
        ref_mem[idx] = old;
      end
      exp_q.push_back(x);
    end
  end

  // Monitor: pop and compare every consumed response.
  always @(negedge clk_i) begin : monitor
    exp_t x;
    if (!rst_i) begin
      if (!resp_ready_i)
        foreach (exp_q[i]) exp_q[i].exact = 1'b0;
      if (resp_valid_o && resp_ready_i) begin
        obs_q.push_back({resp_data_o, resp_wr_o, resp_err_o});
        pop_cnt++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid_o), 64'h0);
        end else begin
          x = exp_q.pop_front();
          chk("resp", {30'h0, resp_data_o, resp_wr_o, resp_err_o}, {30'h0, x.data, x.wr, x.err});
          if (x.exact) chk("resp_latency", 64'(cyc - x.acc_cyc), 64'd2);
          else if (cyc - x.acc_cyc < 2) chk("resp_latency_min", 64'(cyc - x.acc_cyc), 64'd2);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                       output int ac);
    int n = 0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    req_wr_i    = w;
    forever begin
      @(negedge clk_i);
      if (req_ready_o) break;
      n++;
      if (n > 500) begin
        $display("FAIL issue_timeout addr=%0h", a);
        $fatal(1);
      end
    end
    ac = cyc;
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk_i);
      n++;
    end
    @(posedge clk_i); #1;
    chk("drain_left", 64'(exp_q.size()), 64'h0);
  endtask

  task automatic rand_req();
    int r = $urandom_range(0, 9);
    logic [31:0] a;
    if (r < 8)       a = 32'($urandom_range(0, 63)) << 2;
    else if (r == 8) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
    else             a = $urandom | 32'h0001_0000;
    req_addr_i = a;
    req_data_i = $urandom;
    req_wr_i   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ac;
    int first_ac;
    int cnt;
    int sent;
    int iter;
    int pops0;
    bit hit;
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    req_data_i = '0;
    req_wr_i = '0;
    resp_ready_i = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_ready", 64'(req_ready_o), 64'h0);
    chk("rst_resp", {30'h0, resp_valid_o, resp_data_o, resp_wr_o, resp_err_o}, 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_rst", 64'(req_ready_o), 64'h1);
    @(posedge clk_i); #1;

    // Read after write.
    obs_q.delete();
    issue(32'h100, 32'hDEADBEEF, 4'hF, ac);
    issue(32'h100, 32'h0, 4'h0, ac);
    req_valid_i = 1'b0;
    drain();
    chk("raw_count", 64'(obs_q.size()), 64'd2);
    chk("raw_wr_resp", 64'(obs_q[0]), {30'h0, 32'h0, 1'b1, 1'b0});
    chk("raw_rd_resp", 64'(obs_q[1]), {30'h0, 32'hDEADBEEF, 1'b0, 1'b0});

    // Byte strobe.
    obs_q.delete();
    issue(32'h200, 32'h11223344, 4'hF, ac);
    issue(32'h200, 32'hAABBCCDD, 4'b0010, ac);
    issue(32'h200, 32'h0, 4'h0, ac);
    req_valid_i = 1'b0;
    drain();
    chk("strb_wr_resp", 64'(obs_q[1]), {30'h0, 32'h11223344, 1'b1, 1'b0});
    chk("strb_rd_resp", 64'(obs_q[2]), {30'h0, 32'h1122CC44, 1'b0, 1'b0});

    // Errors interleaved with good requests.
    obs_q.delete();
    issue(32'h100, 32'h0, 4'h0, ac);
    issue(32'h102, 32'h0, 4'h0, ac);
    issue(32'h10000, 32'h5555AAAA, 4'hF, ac);
    issue(32'h100, 32'h0, 4'h0, ac);
    req_valid_i = 1'b0;
    drain();
    chk("err_count", 64'(obs_q.size()), 64'd4);
    chk("err_good0", 64'(obs_q[0]), {30'h0, 32'hDEADBEEF, 1'b0, 1'b0});
    chk("err_misalign", 64'(obs_q[1]), {30'h0, 32'h0, 1'b0, 1'b1});
    chk("err_window", 64'(obs_q[2]), {30'h0, 32'h0, 1'b1, 1'b1});
    chk("err_good1", 64'(obs_q[3]), {30'h0, 32'hDEADBEEF, 1'b0, 1'b0});
    @(negedge clk_i);
    chk("empty_hold", {30'h0, resp_valid_o, resp_data_o, resp_wr_o, resp_err_o},
        {30'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0});
    @(posedge clk_i); #1;

    // Backpressure: only DEPTH requests fit.
    pops0 = pop_cnt;
    resp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i = 32'h300;
    req_wr_i = 4'h0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (req_valid_i && req_ready_o) cnt++;
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("bp_accepted", 64'(cnt), 64'd4);
    chk("bp_ready_low", 64'(req_ready_o), 64'h0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) issue(32'h300, 32'h0, 4'h0, ac);
    req_valid_i = 1'b0;
    drain();
    chk("bp_total_resp", 64'(pop_cnt - pops0), 64'd8);

    // Throughput: 64 back-to-back reads.
    first_ac = 0;
    for (int i = 0; i < 64; i++) begin
      issue(32'(i) << 2, 32'h0, 4'h0, ac);
      if (i == 0) first_ac = ac;
    end
    req_valid_i = 1'b0;
    drain();
    chk("tput_accept_span", 64'(ac - first_ac), 64'd63);
    chk("tput_cycles", 64'(last_pop_cyc - first_ac + 1), 64'd66);

    // Randomized traffic with random response backpressure.
    sent = 0;
    iter = 0;
    while (sent < 300 && iter < 5000) begin
      @(negedge clk_i);
      hit = req_valid_i && req_ready_o;
      if (hit) sent++;
      @(posedge clk_i); #1;
      iter++;
      resp_ready_i = ($urandom_range(0, 3) != 0);
      if (hit || !req_valid_i) begin
        if (sent < 300 && $urandom_range(0, 3) != 0) begin
          rand_req();
          req_valid_i = 1'b1;
        end else begin
          req_valid_i = 1'b0;
        end
      end
    end
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    drain();
    chk("rand_sent", 64'(sent), 64'd300);

    // Reset with 3 buffered responses and 1 in flight.
    obs_q.delete();
    resp_ready_i = 1'b0;
    issue(32'h100, 32'h0, 4'h0, ac);
    issue(32'h104, 32'h0, 4'h0, ac);
    issue(32'h108, 32'h0, 4'h0, ac);
    issue(32'h10C, 32'h0, 4'h0, ac);
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_valid_before", 64'(resp_valid_o), 64'h1);
    chk("mid_rst_ready", 64'(req_ready_o), 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_resp", {30'h0, resp_valid_o, resp_data_o, resp_wr_o, resp_err_o}, 64'h0);
    chk("mid_rst_ready_after", 64'(req_ready_o), 64'h1);
    @(posedge clk_i); #1;
    resp_ready_i = 1'b1;
    issue(32'h100, 32'h0, 4'h0, ac);
    issue(32'h200, 32'h0, 4'h0, ac);
    req_valid_i = 1'b0;
    drain();
    chk("post_rst_count", 64'(obs_q.size()), 64'd2);
    chk("post_rst_rd0", 64'(obs_q[0]), {30'h0, 32'hDEADBEEF, 1'b0, 1'b0});
    chk("post_rst_rd1", 64'(obs_q[1]), {30'h0, 32'h1122CC44, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
